// File: rtl/computer_core.sv
// rtl/computer_core.sv - multi-cycle byte-code core with fetch port; optional stack under COMPUTER_CORE_STACK_EN
module computer_core #(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [7:0]        fetch_addr,
  input  logic              fetch_valid,
  input  logic [7:0]        fetch_data,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              equal,
  output logic              greater,
  output logic              lesser,
  output logic              halted,
  output logic              illegal
);

  localparam int RW = $clog2(NREGS);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_CMP  = 8'h05;
  localparam logic [7:0] OP_JEQ  = 8'h08;
  localparam logic [7:0] OP_JNE  = 8'h09;
  localparam logic [7:0] OP_JMP  = 8'h0A;
  localparam logic [7:0] OP_HALT = 8'h0B;

  typedef enum logic [2:0] {S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              reg_we;
  logic [RW-1:0]     reg_wa;
  logic [DATA_W-1:0] reg_wd;

  logic [RW-1:0]     ra_idx, rb_idx;
  logic [DATA_W-1:0] ra_val, rb_val;

  // Register operands only look at the low index bits; the rest of the byte is don't-care.
  assign ra_idx = op1_q[RW-1:0];
  assign rb_idx = op2_q[RW-1:0];
  assign ra_val = regs_q[ra_idx];
  assign rb_val = regs_q[rb_idx];

  assign dbg_data   = regs_q[dbg_sel[RW-1:0]];
  assign fetch_addr = pc_q;
  assign fetch_req  = (state_q == S_FETCH0) || (state_q == S_FETCH1) || (state_q == S_FETCH2);
  assign halted     = (state_q == S_HALT);
  assign equal      = eq_q;
  assign greater    = gt_q;
  assign lesser     = lt_q;
  assign illegal    = illegal_q;

`ifdef COMPUTER_CORE_STACK_EN
  localparam logic [7:0] OP_PUSH = 8'h06;
  localparam logic [7:0] OP_POP  = 8'h07;
  localparam int         SW      = $clog2(STACK_DEPTH);
  localparam logic [SW:0] SP_ONE  = 1;
  localparam logic [SW:0] SP_FULL = STACK_DEPTH[SW:0];

  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [SW:0]       sp_q, sp_d, sp_m1;
  logic              push_en, pop_en;
  logic              stack_full, stack_empty;

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign sp_m1       = sp_q - SP_ONE;

  logic unused_bits;
  assign unused_bits = ^{dbg_sel};
`else
  logic unused_bits;
  assign unused_bits = ^{dbg_sel, STACK_DEPTH};
`endif

  // Next-state, decode and execute: fetch states capture one byte per valid cycle, EXEC commits.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;
    reg_we    = 1'b0;
    reg_wa    = ra_idx;
    reg_wd    = ra_val;
`ifdef COMPUTER_CORE_STACK_EN
    push_en   = 1'b0;
    pop_en    = 1'b0;
    sp_d      = sp_q;
`endif
    case (state_q)
      S_FETCH0: begin
        if (fetch_valid) begin
          opcode_d = fetch_data;
          pc_d     = pc_q + 8'd1;
          case (fetch_data)
            OP_NOP:  state_d = S_FETCH0;
            OP_HALT: state_d = S_HALT;
            OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_CMP,
            OP_JEQ, OP_JNE, OP_JMP: state_d = S_FETCH1;
`ifdef COMPUTER_CORE_STACK_EN
            OP_PUSH, OP_POP: state_d = S_FETCH1;
`endif
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_FETCH1: begin
        if (fetch_valid) begin
          op1_d   = fetch_data;
          pc_d    = pc_q + 8'd1;
          // Opcodes 01..05 carry a second operand; everything else executes now.
          state_d = (opcode_q <= OP_CMP) ? S_FETCH2 : S_EXEC;
        end
      end
      S_FETCH2: begin
        if (fetch_valid) begin
          op2_d   = fetch_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH0;
        case (opcode_q)
          OP_LDI: begin reg_we = 1'b1; reg_wd = DATA_W'(op2_q); end
          OP_MOV: begin reg_we = 1'b1; reg_wd = rb_val; end
          OP_ADD: begin reg_we = 1'b1; reg_wd = ra_val + rb_val; end
          OP_SUB: begin reg_we = 1'b1; reg_wd = ra_val - rb_val; end
          OP_CMP: begin
            eq_d = (ra_val == rb_val);
            gt_d = (ra_val >  rb_val);
            lt_d = (ra_val <  rb_val);
          end
          OP_JEQ: if (eq_q)  pc_d = op1_q;
          OP_JNE: if (!eq_q) pc_d = op1_q;
          OP_JMP: pc_d = op1_q;
`ifdef COMPUTER_CORE_STACK_EN
          OP_PUSH: begin
            if (stack_full) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SP_ONE;
            end
          end
          OP_POP: begin
            if (stack_empty) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              pop_en = 1'b1;
              sp_d   = sp_m1;
              reg_we = 1'b1;
              reg_wd = stack_q[sp_m1[SW-1:0]];
            end
          end
`endif
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Control state register; reset wins over any in-flight fetch or execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH0;
      pc_q      <= '0;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
    end
  end

  // General register file: single write port driven from EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_wa] <= reg_wd;
    end
  end

`ifdef COMPUTER_CORE_STACK_EN
  // Stack pointer counts live entries; reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Stack storage needs no reset since only entries below sp_q are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push_en) stack_q[sp_q[SW-1:0]] <= ra_val;
  end

  logic unused_pop;
  assign unused_pop = pop_en;
`endif

endmodule

// File: tb/tb_computer_core.sv
// tb/tb_computer_core.sv - table-driven bench for computer_core
module tb_computer_core;

`ifdef COMPUTER_CORE_STACK_EN
  localparam int SDEPTH = 2;
`else
  localparam int SDEPTH = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic [3:0] dbg_sel;
  logic [7:0] dbg_data;
  logic       equal, greater, lesser, halted, illegal;

  logic [7:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string        name;
    logic [127:0] prog;
    int           nbytes;
    int           period;
    logic [3:0]   sel;
    logic [7:0]   exp_reg;
    logic         exp_halt;
    logic         exp_ill;
    logic [7:0]   exp_pc;
    logic [2:0]   exp_flags;
  } vec_t;

  vec_t vq[$];

  computer_core #(.DATA_W(8), .NREGS(4), .STACK_DEPTH(SDEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .equal(equal), .greater(greater), .lesser(lesser),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign fetch_data = mem[fetch_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [127:0] prog, input int nbytes,
                         input int period, input logic [3:0] sel, input logic [7:0] exp_reg,
                         input logic exp_halt, input logic exp_ill, input logic [7:0] exp_pc,
                         input logic [2:0] exp_flags);
    vec_t v;
    v.name = name; v.prog = prog; v.nbytes = nbytes; v.period = period; v.sel = sel;
    v.exp_reg = exp_reg; v.exp_halt = exp_halt; v.exp_ill = exp_ill;
    v.exp_pc = exp_pc; v.exp_flags = exp_flags;
    vq.push_back(v);
  endtask

  task automatic load(input logic [127:0] prog, input int n);
    for (int a = 0; a < 256; a++) mem[a] = 8'h0B;
    for (int i = 0; i < n; i++) mem[i] = prog[(n-1-i)*8 +: 8];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    fetch_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input int period, input int budget, output bit timed_out, output bit unstable);
    logic [7:0] last_addr;
    bit waited;
    int cyc;
    waited = 1'b0;
    last_addr = '0;
    cyc = 0;
    timed_out = 1'b1;
    unstable = 1'b0;
    while (cyc < budget) begin
      if (cyc > 0) @(negedge clk);
      if (halted) begin
        timed_out = 1'b0;
        break;
      end
      if (waited && fetch_req && (fetch_addr !== last_addr)) unstable = 1'b1;
      fetch_valid = (period <= 1) ? 1'b1 : ((cyc % period) == (period - 1));
      waited = fetch_req && !fetch_valid;
      last_addr = fetch_addr;
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to, unst, frozen;
    int lat;
    reset = 1'b1;
    fetch_valid = 1'b0;
    dbg_sel = 4'h0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h0B;

    add_vec("sum_fast",  128'h010005_010103_030001_0B, 10, 1, 4'h0, 8'h08, 1, 0, 8'h0A, 3'b000);
    add_vec("sum_slow",  128'h010005_010103_030001_0B, 10, 3, 4'h0, 8'h08, 1, 0, 8'h0A, 3'b000);
    add_vec("wrap_add",  128'h0100FF_010102_030001_050001_0B, 13, 1, 4'h0, 8'h01, 1, 0, 8'h0D, 3'b001);
    add_vec("jeq_taken", 128'h050001_080A_010211_0B, 9, 1, 4'h6, 8'h00, 1, 0, 8'h0B, 3'b100);
    add_vec("jne_fall",  128'h050001_090A_010211_0B, 9, 1, 4'h2, 8'h11, 1, 0, 8'h09, 3'b100);
    add_vec("jmp",       128'h0A05_010077_0B, 6, 1, 4'h0, 8'h00, 1, 0, 8'h06, 3'b000);
    add_vec("self_ops",  128'h010209_030202_020302_040300_04FC07_0B, 16, 2, 4'h0, 8'hEE, 1, 0, 8'h10, 3'b000);
    add_vec("illegal7e", 128'h007E, 2, 1, 4'h0, 8'h00, 1, 1, 8'h02, 3'b000);
    add_vec("cmp_gt",    128'h010009_010102_050001_0B, 10, 1, 4'h0, 8'h09, 1, 0, 8'h0A, 3'b010);
`ifdef COMPUTER_CORE_STACK_EN
    add_vec("push_full", 128'h010005_0600_0600_0600_0B, 10, 1, 4'h0, 8'h05, 1, 1, 8'h09, 3'b000);
    add_vec("push_pop",  128'h010005_0600_010009_0600_0701_0702_0B, 15, 1, 4'h2, 8'h05, 1, 0, 8'h0F, 3'b000);
    add_vec("pop_empty", 128'h0700, 2, 1, 4'h0, 8'h00, 1, 1, 8'h02, 3'b000);
`else
    add_vec("push_undef", 128'h0600, 2, 1, 4'h0, 8'h00, 1, 1, 8'h01, 3'b000);
    add_vec("pop_undef",  128'h0700, 2, 1, 4'h0, 8'h00, 1, 1, 8'h01, 3'b000);
    add_vec("op_ff",      128'hFF, 1, 1, 4'h0, 8'h00, 1, 1, 8'h01, 3'b000);
`endif

    // Reset state and first-cycle fetch request, then minimum 2-operand latency.
    load(128'h010005_0B, 4);
    apply_reset();
    check("rst.fetch_req", 32'(fetch_req), 32'd1);
    check("rst.pc", 32'(fetch_addr), 32'h00);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.flags", 32'({equal, greater, lesser}), 32'd0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 4'(r);
      #1;
      check($sformatf("rst.r%0d", r), 32'(dbg_data), 32'h00);
    end
    dbg_sel = 4'h0;
    fetch_valid = 1'b1;
    lat = 0;
    while (fetch_req && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("lat.exec_at", 32'(lat), 32'd3);
    check("lat.r0_pre", 32'(dbg_data), 32'h00);
    @(negedge clk);
    check("lat.back_fetch", 32'(fetch_req), 32'd1);
    check("lat.r0", 32'(dbg_data), 32'h05);

    // Table of whole programs.
    foreach (vq[k]) begin
      load(vq[k].prog, vq[k].nbytes);
      apply_reset();
      run_prog(vq[k].period, 400, to, unst);
      dbg_sel = vq[k].sel;
      #1;
      check({vq[k].name, ".done"}, 32'(to), 32'd0);
      check({vq[k].name, ".reg"}, 32'(dbg_data), 32'(vq[k].exp_reg));
      check({vq[k].name, ".halted"}, 32'(halted), 32'(vq[k].exp_halt));
      check({vq[k].name, ".illegal"}, 32'(illegal), 32'(vq[k].exp_ill));
      check({vq[k].name, ".pc"}, 32'(fetch_addr), 32'(vq[k].exp_pc));
      check({vq[k].name, ".flags"}, 32'({equal, greater, lesser}), 32'(vq[k].exp_flags));
      if (vq[k].period > 1) check({vq[k].name, ".addr_stable"}, 32'(unst), 32'd0);
      dbg_sel = 4'h0;
    end

    // Undefined opcode: core stays frozen with fetch_req low.
    load(128'h007E, 2);
    apply_reset();
    run_prog(1, 50, to, unst);
    frozen = 1'b1;
    fetch_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (fetch_req !== 1'b0 || fetch_addr !== 8'h02 || halted !== 1'b1) frozen = 1'b0;
    end
    check("ill.frozen", 32'(frozen), 32'd1);
    check("ill.sticky", 32'(illegal), 32'd1);

    // Reset during FETCH1 discards the fetch and clears registers.
    load(128'h010005_010103_030001_0B, 10);
    apply_reset();
    fetch_valid = 1'b1;
    repeat (9) @(negedge clk);
    dbg_sel = 4'h0;
    #1;
    check("midrst.pc_before", 32'(fetch_addr), 32'h07);
    check("midrst.r0_before", 32'(dbg_data), 32'h05);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.pc", 32'(fetch_addr), 32'h00);
    check("midrst.req", 32'(fetch_req), 32'd1);
    check("midrst.r0", 32'(dbg_data), 32'h00);
    dbg_sel = 4'h1;
    #1;
    check("midrst.r1", 32'(dbg_data), 32'h00);
    dbg_sel = 4'h0;
    fetch_valid = 1'b0;

    // JEQ 0x00 after an equal compare returns to address 0.
    load(128'h050001_0800, 5);
    apply_reset();
    fetch_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("jeq0.exec_pc", 32'(fetch_addr), 32'h05);
    @(negedge clk);
    check("jeq0.pc", 32'(fetch_addr), 32'h00);
    check("jeq0.req", 32'(fetch_req), 32'd1);
    fetch_valid = 1'b0;

    // Program counter wraps 0xFF -> 0x00 through a run of NOPs.
    load(128'h09F0_010055_0B, 6);
    mem[8'hF0] = 8'h05; mem[8'hF1] = 8'h00; mem[8'hF2] = 8'h00;
    for (int a = 8'hF3; a <= 8'hFF; a++) mem[a] = 8'h00;
    apply_reset();
    run_prog(1, 200, to, unst);
    dbg_sel = 4'h0;
    #1;
    check("pcwrap.done", 32'(to), 32'd0);
    check("pcwrap.r0", 32'(dbg_data), 32'h55);
    check("pcwrap.pc", 32'(fetch_addr), 32'h06);
    check("pcwrap.flags", 32'({equal, greater, lesser}), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/computer_core.md
COMPUTER_CORE -- requirements
Module: computer_core

Interface
REQ-001 Parameter DATA_W, default 8, register/ALU/stack data width (legal range 8..32).
REQ-002 Parameter NREGS, default 4, number of general registers (power of two, 2..16).
REQ-003 Parameter STACK_DEPTH, default 8, stack entries (power of two, 2..64).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_req  output  1  core requests the code byte at fetch_addr.
REQ-007 fetch_addr  output  8  code byte address (program counter).
REQ-008 fetch_valid  input  1  fetch_data is valid this cycle.
REQ-009 fetch_data  input  8  code byte.
REQ-010 dbg_sel  input  4  register index for debug read; bits above log2(NREGS) ignored.
REQ-011 dbg_data  output  DATA_W  combinational read of register dbg_sel.
REQ-012 equal, greater, lesser  output  1 each  flags from last CMP (unsigned).
REQ-013 halted  output  1  core is in HALT.
REQ-014 illegal  output  1  sticky; set when an undefined or compiled-out opcode is decoded.

Function
REQ-015 Instruction set (opcode byte, then operand bytes): 00 NOP; 01 LDI r,imm8 (zero-extended); 02 MOV rd,rs; 03 ADD rd,rs; 04 SUB rd,rs; 05 CMP ra,rb; 06 PUSH r; 07 POP r; 08 JEQ a; 09 JNE a; 0A JMP a; 0B HALT.
REQ-016 Register operand bytes use low log2(NREGS) bits only; upper bits ignored.
REQ-017 FSM states: FETCH0 (opcode), FETCH1, FETCH2 (operands), EXEC, HALT.
REQ-018 In any FETCH state, fetch_req is 1 and fetch_addr = PC; the byte is captured and PC increments by 1 (mod 256) only in a cycle where fetch_valid = 1.
REQ-019 fetch_req held high and PC stable while fetch_valid = 0; any number of wait cycles is legal.
REQ-020 Operand count: 0 for 00/0B; 1 for 06/07/08/09/0A; 2 for 01–05; FSM skips unneeded FETCH states.
REQ-021 EXEC lasts exactly one cycle, fetch_req = 0, then returns to FETCH0; minimum latency for a 2-operand instruction with fetch_valid tied high is 4 cycles.
REQ-022 NOP and HALT go directly from FETCH0 to FETCH0/HALT without an EXEC cycle.
REQ-023 ADD/SUB wrap modulo 2^DATA_W; flags unchanged by ADD/SUB.
REQ-024 CMP: equal = (ra==rb), greater = (ra>rb), lesser = (ra<rb), unsigned; exactly one set.
REQ-025 JEQ/JNE load PC with operand when equal is 1/0 respectively; JMP always; otherwise PC continues.
REQ-026 PUSH when stack full, or POP when empty: no stack/register change, illegal set, core enters HALT.
REQ-027 Undefined opcode (0C–FF): illegal set, core enters HALT after FETCH0.
REQ-028 HALT: fetch_req = 0, all state frozen; exits only via reset.
REQ-029 PC wraps 0xFF -> 0x00 without error.
REQ-030 MOV/ADD/SUB with rd == rs are legal and use the pre-instruction value.

Reset
REQ-031 On reset = 1 at a clock edge: PC = 0, state = FETCH0, all registers = 0, stack empty, equal/greater/lesser = 0, illegal = 0, halted = 0.
REQ-032 Reset takes priority over every other event, including mid-fetch, mid-EXEC and HALT; a pending fetch is abandoned.
REQ-033 fetch_req = 1 in the first cycle after reset is released.

Configuration
REQ-034 Macro COMPUTER_CORE_STACK_EN: when defined, PUSH/POP and the stack are built per REQ-026.
REQ-035 When COMPUTER_CORE_STACK_EN is undefined, no stack storage exists, and 06/07 are treated as undefined opcodes per REQ-027.

Verification
REQ-036 fetch_valid tied 1, program 01 00 05, 01 01 03, 03 00 01, 0B -> dbg r0 = 8, halted = 1, PC = 0x0A.
REQ-037 Same program with fetch_valid high every third cycle -> identical final state; fetch_addr stable during every wait.
REQ-038 DATA_W = 8: LDI r0,FF; LDI r1,02; ADD r0,r1; CMP r0,r1 -> r0 = 01, lesser = 1.
REQ-039 STACK_EN, STACK_DEPTH = 2: three PUSH r0 -> illegal = 1, halted = 1, third push discarded; POP on empty after reset -> same.
REQ-040 CMP equal then JEQ 0x00 -> PC = 0; JNE 0x00 instead -> falls through; reset asserted during FETCH1 -> PC = 0, all regs 0 next cycle.
REQ-041 Opcode 0x7E -> illegal = 1, halted = 1, fetch_req = 0 thereafter until reset.
